cmp6_pipe: RTL and testbench

CMP6_PIPE -- requirements
Module: cmp6_pipe

---
 rtl/cmp6_pkg.sv | 37 +++
 rtl/cmp6_core.sv | 22 ++
 rtl/cmp6_pipe.sv | 149 ++++++++++++++
 tb/tb_cmp6_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp6_pkg.sv
// Shared types for the cmp6 comparator pipeline: operating modes and the
// six-flag comparison bundle, plus a helper that derives the full bundle.
package cmp6_pkg;

  typedef enum logic [1:0] {
    PAIR   = 2'b00,
    TRKMIN = 2'b01,
    TRKMAX = 2'b10
  } mode_e;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
    logic le;
    logic ge;
    logic ne;
  } flags_t;

  localparam flags_t FLAGS_NONE = '{lt: 1'b0, gt: 1'b0, eq: 1'b0,
                                    le: 1'b0, ge: 1'b0, ne: 1'b0};
  localparam flags_t FLAGS_EQ   = '{lt: 1'b0, gt: 1'b0, eq: 1'b1,
                                    le: 1'b1, ge: 1'b1, ne: 1'b0};

  // Only lt and eq are independent; the rest follow from them.
  function automatic flags_t make_flags(input logic lt_i, input logic eq_i);
    flags_t f;
    f.lt = lt_i;
    f.eq = eq_i;
    f.gt = ~lt_i & ~eq_i;
    f.le = lt_i | eq_i;
    f.ge = ~lt_i;
    f.ne = ~eq_i;
    return f;
  endfunction

endpackage

// File: rtl/cmp6_core.sv
// Combinational magnitude comparator, signed or unsigned per beat.
module cmp6_core
  import cmp6_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             tc,
  output flags_t           flags
);

  logic [WIDTH-1:0] a_key;
  logic [WIDTH-1:0] b_key;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_key = a ^ {tc, {(WIDTH-1){1'b0}}};
  assign b_key = b ^ {tc, {(WIDTH-1){1'b0}}};

  assign flags = make_flags(a_key < b_key, a_key == b_key);

endmodule

// File: rtl/cmp6_pipe.sv
// Pipelined comparator with a min/max tracker; results emerge STAGES cycles
// after acceptance and the whole pipeline stalls on output backpressure.
module cmp6_pipe
  import cmp6_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNTW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             tc,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             le,
  output logic             ge,
  output logic             ne,
  output logic [WIDTH-1:0] ext,
  output logic [CNTW-1:0]  cnt
);

  logic             adv;
  logic             accept;
  logic             is_min;
  logic             is_max;
  logic             is_trk;

  logic [WIDTH-1:0] trk_ext_q;
  logic [CNTW-1:0]  trk_cnt_q;
  logic             trk_have_q;

  logic [WIDTH-1:0] ext_cur;
  logic [CNTW-1:0]  cnt_cur;
  logic             have_cur;

  logic [WIDTH-1:0] cmp_b;
  flags_t           cmp_flags;

  flags_t           res_flags;
  logic [WIDTH-1:0] ext_nxt;
  logic [CNTW-1:0]  cnt_nxt;
  logic             have_nxt;

  logic             vld_q   [STAGES];
  flags_t           flags_q [STAGES];
  logic [WIDTH-1:0] ext_q   [STAGES];
  logic [CNTW-1:0]  cnt_q   [STAGES];

  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = out_ready | ~out_valid;
  assign adv       = in_ready;
  assign accept    = in_valid & in_ready;

  assign is_min = (mode == TRKMIN);
  assign is_max = (mode == TRKMAX);
  assign is_trk = is_min | is_max;

  // A clear in the same cycle as a beat takes effect before that beat.
  assign ext_cur  = clr ? '0 : trk_ext_q;
  assign cnt_cur  = clr ? '0 : trk_cnt_q;
  assign have_cur = ~clr & trk_have_q;

  assign cmp_b = is_trk ? ext_cur : b;

  cmp6_core #(.WIDTH(WIDTH)) u_core (
    .a     (a),
    .b     (cmp_b),
    .tc    (tc),
    .flags (cmp_flags)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    res_flags = cmp_flags;
    ext_nxt   = ext_cur;
    cnt_nxt   = cnt_cur;
    have_nxt  = have_cur;
    if (is_trk) begin
      have_nxt = 1'b1;
      cnt_nxt  = (cnt_cur == '1) ? cnt_cur : cnt_cur + CNTW'(1);
      if (!have_cur) begin
        res_flags = FLAGS_EQ;
        ext_nxt   = a;
      end else if ((is_min && cmp_flags.lt) || (is_max && cmp_flags.gt)) begin
        ext_nxt = a;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_ext_q  <= '0;
      trk_cnt_q  <= '0;
      trk_have_q <= 1'b0;
    end else if (accept) begin
      trk_ext_q  <= ext_nxt;
      trk_cnt_q  <= cnt_nxt;
      trk_have_q <= have_nxt;
    end else if (clr) begin
      trk_ext_q  <= '0;
      trk_cnt_q  <= '0;
      trk_have_q <= 1'b0;
    end
  end

  // NOTE: the pipeline is only STAGES entries deep, so its data registers are
  // reset too; that keeps every output at zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i]   <= 1'b0;
        flags_q[i] <= FLAGS_NONE;
        ext_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else if (adv) begin
      vld_q[0]   <= in_valid;
      flags_q[0] <= res_flags;
      ext_q[0]   <= ext_nxt;
      cnt_q[0]   <= cnt_nxt;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i]   <= vld_q[i-1];
        flags_q[i] <= flags_q[i-1];
        ext_q[i]   <= ext_q[i-1];
        cnt_q[i]   <= cnt_q[i-1];
      end
    end
  end

  assign lt  = flags_q[STAGES-1].lt;
  assign gt  = flags_q[STAGES-1].gt;
  assign eq  = flags_q[STAGES-1].eq;
  assign le  = flags_q[STAGES-1].le;
  assign ge  = flags_q[STAGES-1].ge;
  assign ne  = flags_q[STAGES-1].ne;
  assign ext = ext_q[STAGES-1];
  assign cnt = cnt_q[STAGES-1];

endmodule

// File: tb/tb_cmp6_pipe.sv
// Scoreboard bench for cmp6_pipe: a reference model predicts each accepted
// beat's result, and an independent monitor compares delivered beats in order.
module tb_cmp6_pipe;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam int CNTW   = 2;
  localparam int CMAX   = (1 << CNTW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             tc;
  logic [1:0]       mode;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic             lt, gt, eq, le, ge, ne;
  logic [WIDTH-1:0] ext;
  logic [CNTW-1:0]  cnt;

  cmp6_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .tc        (tc),
    .mode      (mode),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .gt        (gt),
    .eq        (eq),
    .le        (le),
    .ge        (ge),
    .ne        (ne),
    .ext       (ext),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       flags;
    logic [WIDTH-1:0] ext;
    logic [CNTW-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_mode = 0;  // 0 always ready, 1 random, 2 stalled

  // Reference tracker state, kept as plain integers.
  bit   m_have;
  int   m_ext;
  int   m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sval(input logic [WIDTH-1:0] x, input logic tc_i);
    if (tc_i) return int'($signed(x));
    return int'(x);
  endfunction

  function automatic logic [5:0] flag_vec(input int x, input int y);
    bit l = (x < y);
    bit g = (x > y);
    bit e = (x == y);
    return {l, g, e, l | e, g | e, ~e};
  endfunction

  function automatic exp_t model_beat(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                      input logic tc_i, input logic [1:0] mode_i);
    exp_t e;
    int   va;
    int   vx;
    va = sval(a_i, tc_i);
    if (mode_i == 2'd1 || mode_i == 2'd2) begin
      if (!m_have) begin
        e.flags = 6'b001110;
        m_ext   = int'(a_i);
        m_have  = 1'b1;
      end else begin
        vx      = sval(m_ext[WIDTH-1:0], tc_i);
        e.flags = flag_vec(va, vx);
        if ((mode_i == 2'd1 && va < vx) || (mode_i == 2'd2 && va > vx)) m_ext = int'(a_i);
      end
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      e.flags = flag_vec(va, sval(b_i, tc_i));
    end
    e.ext = m_ext[WIDTH-1:0];
    e.cnt = m_cnt[CNTW-1:0];
    return e;
  endfunction

  // Model: observes what the DUT will accept at the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_have = 1'b0;
      m_ext  = 0;
      m_cnt  = 0;
    end else begin
      if (clr) begin
        m_have = 1'b0;
        m_ext  = 0;
        m_cnt  = 0;
      end
      if (in_valid && in_ready) sb.push_back(model_beat(a, b, tc, mode));
    end
  end

  // Monitor: compares delivered beats and output stability under stall.
  logic             hold;
  logic [5:0]       snap_flags;
  logic [WIDTH-1:0] snap_ext;
  logic [CNTW-1:0]  snap_cnt;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {lt, gt, eq, le, ge, ne, ext, cnt}, {snap_flags, snap_ext, snap_cnt});
      end
      if (out_valid && out_ready) begin
        hold = 1'b0;
        if (sb.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("flags", {lt, gt, eq, le, ge, ne}, e.flags);
          check("ext", ext, e.ext);
          check("cnt", cnt, e.cnt);
        end
      end else if (out_valid) begin
        hold       = 1'b1;
        snap_flags = {lt, gt, eq, le, ge, ne};
        snap_ext   = ext;
        snap_cnt   = cnt;
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one beat (called just after a rising edge) until it is accepted.
  task automatic send_beat(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                           input logic tc_i, input logic [1:0] mode_i, input logic clr_i);
    logic ok;
    ok       = 1'b0;
    a        = a_i;
    b        = b_i;
    tc       = tc_i;
    mode     = mode_i;
    clr      = clr_i;
    in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      clr = 1'b0;
      if (ok) break;
    end
    in_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (sb.size() == 0) break;
      idle(1);
    end
    check("drain", sb.size(), 0);
    idle(2);
  endtask

  task automatic latency_check(input logic [5:0] want);
    int lat;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check("latency", lat, STAGES);
    check("pair_flags", {lt, gt, eq, le, ge, ne}, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    tc       = 1'b0;
    mode     = 2'd0;
    clr      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {lt, gt, eq, le, ge, ne}, 0);
    check("rst_ext", ext, 0);
    check("rst_cnt", cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Signed vs unsigned on the same operands.
    send_beat(8'h80, 8'h7F, 1'b1, 2'd0, 1'b0);
    latency_check(6'b100101);
    drain();
    send_beat(8'h80, 8'h7F, 1'b0, 2'd0, 1'b0);
    latency_check(6'b010011);
    drain();

    // Max tracking sequence.
    send_beat(8'd5, 8'd0, 1'b0, 2'd2, 1'b1);
    send_beat(8'd9, 8'd0, 1'b0, 2'd2, 1'b0);
    send_beat(8'd3, 8'd0, 1'b0, 2'd2, 1'b0);
    send_beat(8'd9, 8'd0, 1'b0, 2'd2, 1'b0);
    drain();

    // Full pipeline held for five cycles, with a further beat waiting.
    ready_mode = 2;
    idle(2);
    for (int i = 0; i < STAGES; i++) send_beat(8'($urandom), 8'($urandom), 1'b1, 2'd0, 1'b0);
    fork
      send_beat(8'h11, 8'h22, 1'b0, 2'd0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
      end
    join
    drain();

    // Min tracking, then clear together with a new beat.
    send_beat(8'd120, 8'd0, 1'b0, 2'd1, 1'b1);
    send_beat(8'd80,  8'd0, 1'b0, 2'd1, 1'b0);
    send_beat(8'd150, 8'd0, 1'b0, 2'd1, 1'b0);
    send_beat(8'd200, 8'd0, 1'b0, 2'd1, 1'b1);
    drain();

    // Counter saturation, then reset with beats in flight.
    for (int i = 0; i < 6; i++) send_beat(8'($urandom), 8'd0, 1'($urandom), 2'd2, i == 0);
    drain();
    for (int i = 0; i < 3; i++) send_beat(8'($urandom), 8'd0, 1'b0, 2'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ext", ext, 0);
    check("midrst_cnt", cnt, 0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send_beat(8'd77, 8'd0, 1'b1, 2'd2, 1'b0);
    drain();

    // Randomized traffic with random backpressure and occasional clears.
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2) == 0 ? 1 : 0);
      send_beat(8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom),
                $urandom_range(0, 7) == 0);
    end
    ready_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
